if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/if_stage_if.sv | 13 +
 rtl/if_id_reg.sv | 34 +++
 rtl/if_stage.sv | 158 +++++++++++++++
 tb/tb_if_stage.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word width, NOP encoding, fetch FSM states
// and the IF/ID pipeline payload.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // sll $0,$0,0
  localparam word_t NOP_INSTR_WORD = 32'h0000_0000;

  // Fetch FSM state encoding
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // IF/ID pipeline register contents
  typedef struct packed {
    word_t pc4;
    word_t instr;
    logic  valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface if_stage_if;
  import cpu_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  word_t imem_rdata;
  logic  imem_valid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble (pc4 kept), write-enable loads
// a new entry, otherwise the contents hold.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_we,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  // Bubble has priority over a load so a redirect can kill the slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q.pc4   <= '0;
      r_q.instr <= NOP_INSTR;
      r_q.valid <= 1'b0;
    end else if (i_flush) begin
      r_q.instr <= NOP_INSTR;
      r_q.valid <= 1'b0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, REQ/WAIT/HOLD fetch FSM and IF/ID register.
// Build option IF_ID_FLUSH_EN: branch_taken flushes IF/ID and discards the
// outstanding fetch; without it a redirect takes effect after the fetch in
// progress (delay slot).
module if_stage
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  PCWrite,
  input  logic  IF_ID_Write,
  input  logic  branch_taken,
  input  word_t branch_target,
  if_stage_if.master imem,
  output word_t IF_ID_PC4,
  output word_t IF_ID_Instr,
  output logic  IF_ID_Valid
);

  logic [1:0] r_state, w_state_nxt;
  word_t      r_pc, w_pc_nxt;
  word_t      r_hold, w_hold_nxt;
  logic       r_discard, w_discard_nxt;
  logic       r_pend, w_pend_nxt;
  word_t      r_target, w_target_nxt;
  logic       r_req;

  logic       w_stall;
  word_t      w_pc4;
  word_t      w_pc_seq;
  logic       w_id_we;
  logic       w_id_flush;
  if_id_t     w_id_d;
  if_id_t     w_id_q;

  assign w_stall  = !PCWrite || !IF_ID_Write;
  assign w_pc4    = r_pc + 32'd4;
  assign w_pc_seq = r_pend ? r_target : w_pc4;

  // Next-state, next-PC and IF/ID control. The IF/ID slot is refilled with a
  // bubble in every unstalled cycle that does not deliver, so each fetched
  // instruction is presented valid for exactly one cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_hold_nxt    = r_hold;
    w_discard_nxt = r_discard;
    w_pend_nxt    = r_pend;
    w_target_nxt  = r_target;
    w_id_we       = 1'b0;
    w_id_flush    = 1'b0;
    w_id_d        = '{pc4: w_pc4, instr: imem.imem_rdata, valid: 1'b1};

    case (r_state)
      ST_REQ: begin
        w_state_nxt = ST_WAIT;
        w_id_flush  = !w_stall;
      end
      ST_WAIT: begin
        if (imem.imem_valid) begin
          if (r_discard) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = ST_REQ;
            w_id_flush    = !w_stall;
          end else if (w_stall) begin
            w_hold_nxt  = imem.imem_rdata;
            w_state_nxt = ST_HOLD;
          end else begin
            w_id_we     = 1'b1;
            w_pc_nxt    = w_pc_seq;
            w_pend_nxt  = 1'b0;
            w_state_nxt = ST_REQ;
          end
        end else begin
          w_id_flush = !w_stall;
        end
      end
      ST_HOLD: begin
        if (!w_stall) begin
          w_id_we      = 1'b1;
          w_id_d.instr = r_hold;
          w_pc_nxt     = w_pc_seq;
          w_pend_nxt   = 1'b0;
          w_state_nxt  = ST_REQ;
        end
      end
      default: w_state_nxt = ST_REQ;
    endcase

`ifdef IF_ID_FLUSH_EN
    // Redirect wins over stall: kill IF/ID and whatever fetch is in flight
    if (branch_taken) begin
      w_pc_nxt   = branch_target;
      w_id_flush = 1'b1;
      w_id_we    = 1'b0;
      w_pend_nxt = 1'b0;
      if ((r_state == ST_REQ) || ((r_state == ST_WAIT) && !imem.imem_valid)) begin
        w_state_nxt   = ST_WAIT;
        w_discard_nxt = 1'b1;
      end else begin
        w_state_nxt   = ST_REQ;
        w_discard_nxt = 1'b0;
      end
    end
`else
    // Delay slot: current fetch completes, redirect applies at the next PC update
    if (branch_taken) begin
      if (w_id_we) begin
        w_pc_nxt = branch_target;
      end else begin
        w_pend_nxt   = 1'b1;
        w_target_nxt = branch_target;
      end
    end
`endif
  end

  // Fetch state, PC and side registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_REQ;
      r_pc      <= RESET_PC;
      r_hold    <= '0;
      r_discard <= 1'b0;
      r_pend    <= 1'b0;
      r_target  <= '0;
      r_req     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_hold    <= w_hold_nxt;
      r_discard <= w_discard_nxt;
      r_pend    <= w_pend_nxt;
      r_target  <= w_target_nxt;
      r_req     <= (w_state_nxt == ST_REQ);
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_id_we),
    .i_flush (w_id_flush),
    .i_d     (w_id_d),
    .o_q     (w_id_q)
  );

  assign IF_ID_PC4   = w_id_q.pc4;
  assign IF_ID_Instr = w_id_q.instr;
  assign IF_ID_Valid = w_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: table of fetch/stall vectors, branch,
// wrap-around and reset-abandon sequences; delivered instructions are checked
// through a scoreboard queue filled when the memory model responds.
module tb_if_stage;
  import cpu_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  PCWrite, IF_ID_Write, branch_taken;
  word_t branch_target;
  word_t IF_ID_PC4, IF_ID_Instr;
  logic  IF_ID_Valid;

  if_stage_if imem ();

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem),
    .IF_ID_PC4     (IF_ID_PC4),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_Valid   (IF_ID_Valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned lat;      // cycle (after the REQ cycle) carrying imem_valid
    int unsigned stl;      // stall asserted for cycles 0..stl-1
    logic [1:0]  sel;      // bit0 drops PCWrite, bit1 drops IF_ID_Write
    bit          spur;     // junk imem_valid in REQ and right after the response
    int unsigned exp_cyc;  // cycle at which the new IF/ID entry is visible
  } vec_t;

  typedef struct {
    word_t pc4;
    word_t instr;
  } exp_t;

  vec_t  vecs[8];
  exp_t  sbq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  word_t m_pc;

  function automatic word_t mem_word(input word_t a);
    if (a == 32'h0) return 32'h2008_0005;
    return 32'h3C00_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    PCWrite          = 1'b1;
    IF_ID_Write      = 1'b1;
    branch_taken     = 1'b0;
    branch_target    = '0;
    imem.imem_valid  = 1'b0;
    imem.imem_rdata  = '0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (imem.imem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_req"}, 32'(imem.imem_req), 32'd1);
    chk({name, "_addr"}, imem.imem_addr, m_pc);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    chk({name, "_sb"}, 32'(sbq.size() > 0 && IF_ID_Valid === 1'b1), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({name, "_instr"}, IF_ID_Instr, e.instr);
      chk({name, "_pc4"}, IF_ID_PC4, e.pc4);
    end
  endtask

  // One fetch under a given memory latency and stall pattern
  task automatic run_fetch(input vec_t v, input string name);
    word_t a;
    word_t s_pc4, s_ins;
    logic  s_v;
    bit    hold_ok = 1'b1;
    int    got = -1;
    wait_req(name);
    a     = imem.imem_addr;
    s_pc4 = IF_ID_PC4;
    s_ins = IF_ID_Instr;
    s_v   = IF_ID_Valid;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 1 && c <= int'(v.stl) &&
          (IF_ID_PC4 !== s_pc4 || IF_ID_Instr !== s_ins || IF_ID_Valid !== s_v))
        hold_ok = 1'b0;
      if (IF_ID_Valid === 1'b1 && IF_ID_PC4 === a + 32'd4) begin
        got = c;
        break;
      end
      PCWrite         = !(c < int'(v.stl) && v.sel[0]);
      IF_ID_Write     = !(c < int'(v.stl) && v.sel[1]);
      imem.imem_valid = 1'b0;
      imem.imem_rdata = '0;
      if (c == int'(v.lat)) begin
        imem.imem_valid = 1'b1;
        imem.imem_rdata = mem_word(a);
        sbq.push_back('{pc4: a + 32'd4, instr: mem_word(a)});
      end else if (v.spur && (c == 0 || c == int'(v.lat) + 1)) begin
        imem.imem_valid = 1'b1;
        imem.imem_rdata = 32'hDEAD_BEEF;
      end
    end
    drive_idle();
    chk({name, "_lat"}, 32'(got), 32'(v.exp_cyc));
    pop_check(name);
    if (v.stl > 0) chk({name, "_hold"}, 32'(hold_ok), 32'd1);
    m_pc = a + 32'd4;
  endtask

  // Redirect while a fetch is outstanding; response in the same or next cycle
  task automatic branch_seq(input word_t target, input bit coincident, input string name);
    word_t a;
    wait_req(name);
    a = imem.imem_addr;
    @(negedge clk);
    branch_taken  = 1'b1;
    branch_target = target;
    if (coincident) begin
      imem.imem_valid = 1'b1;
      imem.imem_rdata = mem_word(a);
`ifndef IF_ID_FLUSH_EN
      sbq.push_back('{pc4: a + 32'd4, instr: mem_word(a)});
`endif
    end
    @(negedge clk);
    drive_idle();
    if (!coincident) begin
      chk({name, "_bubble"}, 32'(IF_ID_Valid), 32'd0);
      imem.imem_valid = 1'b1;
      imem.imem_rdata = mem_word(a);
`ifndef IF_ID_FLUSH_EN
      sbq.push_back('{pc4: a + 32'd4, instr: mem_word(a)});
`endif
      @(negedge clk);
      drive_idle();
    end
    chk({name, "_req"}, 32'(imem.imem_req), 32'd1);
    chk({name, "_addr"}, imem.imem_addr, target);
`ifdef IF_ID_FLUSH_EN
    chk({name, "_flushed"}, 32'(IF_ID_Valid), 32'd0);
    chk({name, "_sb_empty"}, 32'(sbq.size()), 32'd0);
`else
    pop_check(name);
`endif
    m_pc = target;
  endtask

  initial begin
    vecs[0] = '{1, 0, 2'b00, 1'b0, 2};
    vecs[1] = '{2, 0, 2'b00, 1'b0, 3};
    vecs[2] = '{1, 3, 2'b11, 1'b0, 4};
    vecs[3] = '{3, 1, 2'b01, 1'b0, 4};
    vecs[4] = '{2, 2, 2'b10, 1'b0, 3};
    vecs[5] = '{1, 4, 2'b01, 1'b1, 5};
    vecs[6] = '{1, 1, 2'b10, 1'b0, 2};
    vecs[7] = '{3, 5, 2'b11, 1'b1, 6};

    drive_idle();
    rst  = 1'b1;
    m_pc = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(IF_ID_Valid), 32'd0);
    chk("rst_instr", IF_ID_Instr, 32'h0);
    chk("rst_pc4", IF_ID_PC4, 32'h0);
    chk("rst_addr", imem.imem_addr, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_fetch(vecs[i], $sformatf("vec%0d", i));

    branch_seq(32'h0000_0040, 1'b0, "br_wait");
    branch_seq(32'h0000_0100, 1'b1, "br_coinc");
    branch_seq(32'hFFFF_FFFC, 1'b0, "br_top");
    run_fetch('{1, 0, 2'b00, 1'b0, 2}, "wrap");
    run_fetch('{1, 0, 2'b00, 1'b0, 2}, "after_wrap");

    // Reset during WAIT; a late response in the first post-reset cycle is ignored
    wait_req("pre_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(IF_ID_Valid), 32'd0);
    rst             = 1'b0;
    imem.imem_valid = 1'b1;
    imem.imem_rdata = 32'h1234_5678;
    chk("post_rst_req", 32'(imem.imem_req), 32'd1);
    chk("post_rst_addr", imem.imem_addr, 32'h0);
    @(negedge clk);
    chk("late_valid_ignored", 32'(IF_ID_Valid), 32'd0);
    chk("post_rst_wait", 32'(imem.imem_req), 32'd0);
    imem.imem_rdata = mem_word(32'h0);
    sbq.push_back('{pc4: 32'h4, instr: mem_word(32'h0)});
    @(negedge clk);
    drive_idle();
    pop_check("post_rst_fetch");
    chk("post_rst_next", imem.imem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
